// File: rtl/bus_arbiter_rr_bcast.sv
// Shared-bus arbiter: picks one pending driver FIFO (round-robin or fixed
// priority), pops its head packet and delivers it to one destination RX FIFO
// or broadcasts it to every other driver. Packets with an unknown destination
// are dropped with a one-cycle error pulse. Completed deliveries are counted.
module bus_arbiter_rr_bcast #(
  parameter int unsigned     PCKG_SZ = 16,
  parameter int unsigned     DRVRS   = 8,
  parameter int unsigned     ID_W    = 8,
  parameter logic [ID_W-1:0] BCAST   = ID_W'(8'hFF),
  parameter int unsigned     CNT_W   = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       prio_mode,
  input  logic [DRVRS-1:0]           pndng,
  input  logic [DRVRS*PCKG_SZ-1:0]   D_pop,
  input  logic [DRVRS-1:0]           full,
  output logic [DRVRS-1:0]           pop,
  output logic [DRVRS-1:0]           push,
  output logic [PCKG_SZ-1:0]         D_push,
  output logic [$clog2(DRVRS)-1:0]   grant_id,
  output logic                       busy,
  output logic                       drop_err,
  output logic [CNT_W-1:0]           pkt_cnt
);

  localparam int unsigned GW = $clog2(DRVRS);
  // One extra bit so pointer + offset can exceed DRVRS before wrapping.
  localparam int unsigned IW = GW + 1;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_POP     = 2'd1;
  localparam logic [1:0] S_DELIVER = 2'd2;

  // State and registered outputs
  logic [1:0]         r_state;
  logic [GW-1:0]      r_ptr;
  logic [GW-1:0]      r_grant;
  logic [PCKG_SZ-1:0] r_pkt;
  logic [DRVRS-1:0]   r_pop;
  logic [DRVRS-1:0]   r_push;
  logic [PCKG_SZ-1:0] r_dpush;
  logic               r_busy;
  logic               r_drop;
  logic [CNT_W-1:0]   r_cnt;

  // Next-state values
  logic [1:0]         w_state_nxt;
  logic [GW-1:0]      w_ptr_nxt;
  logic [GW-1:0]      w_grant_nxt;
  logic [DRVRS-1:0]   w_pop_nxt;
  logic [DRVRS-1:0]   w_push_nxt;
  logic [PCKG_SZ-1:0] w_dpush_nxt;
  logic               w_drop_nxt;
  logic [CNT_W-1:0]   w_cnt_nxt;
  logic               w_cap;

  // Arbitration results
  logic               w_rr_found;
  logic [GW-1:0]      w_rr_idx;
  logic [IW-1:0]      w_sum;
  logic               w_fx_found;
  logic [GW-1:0]      w_fx_idx;
  logic [GW-1:0]      w_win;

  // Destination decode
  logic [PCKG_SZ-1:0] w_head;
  logic [PCKG_SZ-1:0] w_pkt;
  logic [ID_W-1:0]    w_dst;
  logic               w_is_bcast;
  logic               w_is_uni;
  logic               w_invalid;
  logic [DRVRS-1:0]   w_uni_mask;
  logic [DRVRS-1:0]   w_self;
  logic [DRVRS-1:0]   w_mask;
  logic               w_ready;

  // Round-robin search: first pending driver after the pointer, wrapping.
  always_comb begin
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    w_sum      = '0;
    for (int unsigned k = 1; k <= DRVRS; k++) begin
      w_sum = IW'(r_ptr) + IW'(k);
      if (w_sum >= IW'(DRVRS)) begin
        w_sum = w_sum - IW'(DRVRS);
      end
      if (!w_rr_found && pndng[GW'(w_sum)]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = GW'(w_sum);
      end
    end
  end

  // Fixed priority: lowest pending index wins.
  always_comb begin
    w_fx_found = 1'b0;
    w_fx_idx   = '0;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      if (!w_fx_found && pndng[i]) begin
        w_fx_found = 1'b1;
        w_fx_idx   = GW'(i);
      end
    end
  end

  assign w_win = prio_mode ? w_fx_idx : w_rr_idx;

  // Head packet of the granted TX FIFO.
  always_comb begin
    w_head = '0;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      if (r_grant == GW'(i)) begin
        w_head = D_pop[i*PCKG_SZ +: PCKG_SZ];
      end
    end
  end

  // During POP the packet is still on D_pop; afterwards it sits in r_pkt.
  assign w_pkt      = (r_state == S_POP) ? w_head : r_pkt;
  assign w_dst      = w_pkt[PCKG_SZ-1 -: ID_W];
  assign w_is_bcast = (w_dst == BCAST);
  assign w_is_uni   = (w_dst < ID_W'(DRVRS));
  assign w_invalid  = !w_is_bcast && !w_is_uni;

  // Destination masks: unicast target and "everyone but the source".
  always_comb begin
    w_uni_mask = '0;
    w_self     = '0;
    for (int unsigned i = 0; i < DRVRS; i++) begin
      w_uni_mask[i] = (w_dst == ID_W'(i));
      w_self[i]     = (r_grant == GW'(i));
    end
  end

  assign w_mask  = w_is_bcast ? ~w_self : (w_is_uni ? w_uni_mask : '0);
  assign w_ready = ((w_mask & full) == '0);

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_grant_nxt = r_grant;
    w_pop_nxt   = '0;
    w_push_nxt  = '0;
    w_dpush_nxt = r_dpush;
    w_drop_nxt  = 1'b0;
    w_cnt_nxt   = r_cnt;
    w_cap       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (|pndng) begin
          w_grant_nxt = w_win;
          for (int unsigned i = 0; i < DRVRS; i++) begin
            w_pop_nxt[i] = (w_win == GW'(i));
          end
          w_state_nxt = S_POP;
        end
      end
      S_POP: begin
        w_cap     = 1'b1;
        w_ptr_nxt = r_grant;
        if (w_invalid) begin
          w_drop_nxt  = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_DELIVER;
          if (w_ready) begin
            w_push_nxt  = w_mask;
            w_dpush_nxt = w_pkt;
            w_cnt_nxt   = r_cnt + CNT_W'(1);
          end
        end
      end
      S_DELIVER: begin
        // A non-zero r_push means the push strobe is on the bus this cycle.
        if ((r_push != '0) || w_invalid) begin
          w_state_nxt = S_IDLE;
        end else if (w_ready) begin
          w_push_nxt  = w_mask;
          w_dpush_nxt = w_pkt;
          w_cnt_nxt   = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_ptr   <= GW'(DRVRS - 1);
      r_grant <= '0;
      r_pkt   <= '0;
      r_pop   <= '0;
      r_push  <= '0;
      r_dpush <= '0;
      r_busy  <= 1'b0;
      r_drop  <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_grant <= w_grant_nxt;
      r_pop   <= w_pop_nxt;
      r_push  <= w_push_nxt;
      r_dpush <= w_dpush_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_drop  <= w_drop_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_cap) begin
        r_pkt <= w_head;
      end
    end
  end

  assign pop      = r_pop;
  assign push     = r_push;
  assign D_push   = r_dpush;
  assign grant_id = r_grant;
  assign busy     = r_busy;
  assign drop_err = r_drop;
  assign pkt_cnt  = r_cnt;

endmodule

// File: tb/tb_bus_arbiter_rr_bcast.sv
// Bench for bus_arbiter_rr_bcast: TX FIFO queues feed the DUT, a monitor
// predicts each grant and delivery from a packet-level model and checks the
// bus through a scoreboard queue. Directed scenarios precede a random run.
module tb_bus_arbiter_rr_bcast;

  localparam int unsigned PW = 16;
  localparam int unsigned ND = 8;
  localparam int unsigned GW = 3;
  localparam int unsigned CW = 16;

  typedef struct {
    logic [ND-1:0] mask;
    logic [PW-1:0] data;
    bit            drop;
  } exp_t;

  logic              clk = 1'b0;
  logic              reset;
  logic              prio_mode;
  logic [ND-1:0]     pndng;
  logic [ND*PW-1:0]  D_pop;
  logic [ND-1:0]     full;
  logic [ND-1:0]     pop;
  logic [ND-1:0]     push;
  logic [PW-1:0]     D_push;
  logic [GW-1:0]     grant_id;
  logic              busy;
  logic              drop_err;
  logic [CW-1:0]     pkt_cnt;

  bus_arbiter_rr_bcast dut (
    .clk       (clk),
    .reset     (reset),
    .prio_mode (prio_mode),
    .pndng     (pndng),
    .D_pop     (D_pop),
    .full      (full),
    .pop       (pop),
    .push      (push),
    .D_push    (D_push),
    .grant_id  (grant_id),
    .busy      (busy),
    .drop_err  (drop_err),
    .pkt_cnt   (pkt_cnt)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [PW-1:0] tx_q [ND][$];
  exp_t          exp_q [$];
  int            grant_log [$];
  logic [ND-1:0] prev_pop = '0;
  int            m_ptr = ND - 1;
  int            m_cnt = 0;
  int            d_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference arbitration from the pending set, mode and last winner.
  function automatic int ref_pick(input logic [ND-1:0] p, input logic mode, input int ptr);
    if (mode) begin
      for (int i = 0; i < ND; i++) if (p[i]) return i;
    end else begin
      for (int k = 1; k <= ND; k++) if (p[(ptr + k) % ND]) return (ptr + k) % ND;
    end
    return -1;
  endfunction

  // Reference routing of one packet popped from source g.
  function automatic exp_t ref_route(input logic [PW-1:0] pkt, input int g);
    exp_t e;
    int   dst;
    dst    = int'(pkt[15:8]);
    e.data = pkt;
    e.drop = 1'b0;
    if (dst == 255)      e.mask = ~(8'(1) << g);
    else if (dst < ND)   e.mask = 8'(1) << dst;
    else begin
      e.mask = '0;
      e.drop = 1'b1;
    end
    return e;
  endfunction

  task automatic drive_inputs();
    for (int i = 0; i < ND; i++) begin
      pndng[i] = (tx_q[i].size() != 0);
      D_pop[i*PW +: PW] = (tx_q[i].size() != 0) ? tx_q[i][0] : 16'h0;
    end
  endtask

  // One cycle: FIFO heads advance one cycle after the pop strobe was seen.
  task automatic tick();
    @(negedge clk);
    for (int i = 0; i < ND; i++) begin
      if (prev_pop[i] && tx_q[i].size() != 0) tx_q[i].delete(0);
    end
    prev_pop = reset ? pop : '0;
    drive_inputs();
  endtask

  task automatic send(input int drv, input logic [PW-1:0] pkt);
    tx_q[drv].push_back(pkt);
    drive_inputs();
  endtask

  function automatic bit all_idle();
    for (int i = 0; i < ND; i++) if (tx_q[i].size() != 0) return 1'b0;
    return (busy == 1'b0) && (exp_q.size() == 0);
  endfunction

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while (!all_idle() && n < budget) begin
      tick();
      n++;
    end
    check("drain_within_budget", 32'(all_idle()), 32'd1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    full = '0;
    prio_mode = 1'b0;
    for (int i = 0; i < ND; i++) tx_q[i].delete();
    prev_pop = '0;
    drive_inputs();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  // Monitor and scoreboard.
  logic [ND-1:0] mon_pndng;
  logic          mon_mode;
  logic          mon_rst;
  int            mon_g;
  exp_t          mon_e;

  always @(posedge clk) begin
    mon_pndng = pndng;
    mon_mode  = prio_mode;
    mon_rst   = reset;
    #1;
    if (!mon_rst || !reset) begin
      m_ptr = ND - 1;
      m_cnt = 0;
      exp_q.delete();
    end else begin
      if (pop != '0) begin
        mon_g = ref_pick(mon_pndng, mon_mode, m_ptr);
        check("grant_id", 32'(grant_id), mon_g);
        check("pop_onehot", 32'(pop), 32'(1) << mon_g);
        if (mon_g >= 0 && tx_q[mon_g].size() != 0) begin
          m_ptr = mon_g;
          grant_log.push_back(mon_g);
          exp_q.push_back(ref_route(tx_q[mon_g][0], mon_g));
        end
      end
      if (push != '0 || drop_err) begin
        if (exp_q.size() == 0) begin
          check("unexpected_bus_activity", 32'(push), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("push_mask", 32'(push), 32'(mon_e.mask));
          check("drop_err", 32'(drop_err), 32'(mon_e.drop));
          if (!mon_e.drop) begin
            check("D_push", 32'(D_push), 32'(mon_e.data));
            m_cnt = (m_cnt + 1) % 65536;
          end
          check("pkt_cnt", 32'(pkt_cnt), 32'(m_cnt));
        end
      end
      check("pop_push_exclusive", 32'(pop & push), 32'd0);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [PW-1:0] rpkt;
  int            rsel;
  int            rdrv;
  int            rdst;

  initial begin
    reset     = 1'b0;
    prio_mode = 1'b0;
    full      = '0;
    drive_inputs();
    @(negedge clk);
    check("rst_pop", 32'(pop), 32'd0);
    check("rst_push", 32'(push), 32'd0);
    check("rst_D_push", 32'(D_push), 32'd0);
    check("rst_grant_id", 32'(grant_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_drop_err", 32'(drop_err), 32'd0);
    check("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Basic unicast latency
    tick();
    send(0, 16'h0355);
    tick();
    check("uni_pop", 32'(pop), 32'h01);
    check("uni_busy", 32'(busy), 32'd1);
    tick();
    check("uni_push", 32'(push), 32'h08);
    check("uni_D_push", 32'(D_push), 32'h0355);
    check("uni_pkt_cnt", 32'(pkt_cnt), 32'd1);
    check("uni_no_pop", 32'(pop), 32'd0);
    wait_drain(50);

    // Round-robin fairness from a fresh pointer
    do_reset();
    d_cnt = 0;
    grant_log.delete();
    tick();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < ND; i++) send(i, {8'((i + 1) % ND), 8'(r * 16 + i)});
    wait_drain(300);
    d_cnt += 16;
    check("rr_count", 32'(grant_log.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      if (k < grant_log.size()) check("rr_seq", grant_log[k], k % ND);

    // Fixed priority keeps serving driver 0 while it is pending
    prio_mode = 1'b1;
    grant_log.delete();
    tick();
    for (int r = 0; r < 4; r++) send(0, {8'h02, 8'(r)});
    for (int i = 1; i < ND; i++) send(i, {8'h02, 8'(16 + i)});
    wait_drain(300);
    d_cnt += 11;
    check("fx_count", 32'(grant_log.size()), 32'd11);
    for (int k = 0; k < 4; k++)
      if (k < grant_log.size()) check("fx_seq", grant_log[k], 0);
    prio_mode = 1'b0;

    // Destination back-pressure
    full[5] = 1'b1;
    tick();
    send(2, 16'h0512);
    repeat (2) tick();
    for (int c = 0; c < 10; c++) begin
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_no_push", 32'(push), 32'd0);
      tick();
    end
    full[5] = 1'b0;
    tick();
    check("bp_push", 32'(push), 32'h20);
    check("bp_pkt_cnt", 32'(pkt_cnt), 32'(d_cnt + 1));
    d_cnt++;
    wait_drain(50);

    // Broadcast counts once
    tick();
    send(3, 16'hFFAA);
    repeat (2) tick();
    check("bc_push", 32'(push), 32'hF7);
    check("bc_D_push", 32'(D_push), 32'hFFAA);
    check("bc_pkt_cnt", 32'(pkt_cnt), 32'(d_cnt + 1));
    d_cnt++;
    wait_drain(50);

    // Invalid destination is dropped
    tick();
    send(1, 16'h0901);
    repeat (2) tick();
    check("inv_drop_err", 32'(drop_err), 32'd1);
    check("inv_no_push", 32'(push), 32'd0);
    check("inv_idle", 32'(busy), 32'd0);
    check("inv_pkt_cnt", 32'(pkt_cnt), 32'(d_cnt));
    tick();
    check("inv_drop_pulse", 32'(drop_err), 32'd0);
    wait_drain(50);

    // Asynchronous reset while a delivery is stalled
    full[4] = 1'b1;
    tick();
    send(6, 16'h0406);
    repeat (4) tick();
    check("mid_busy", 32'(busy), 32'd1);
    #2 reset = 1'b0;
    #1;
    check("mid_rst_push", 32'(push), 32'd0);
    check("mid_rst_pop", 32'(pop), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    reset = 1'b1;
    full  = '0;
    tick();
    check("mid_pkt_cnt", 32'(pkt_cnt), 32'd0);
    check("mid_pkt_gone", 32'(busy), 32'd0);
    grant_log.delete();
    send(0, 16'h0101);
    send(7, 16'h0102);
    wait_drain(50);
    check("mid_rr_count", 32'(grant_log.size()), 32'd2);
    if (grant_log.size() > 0) check("mid_rr_first", grant_log[0], 0);

    // Random traffic against the reference model
    for (int c = 0; c < 3000; c++) begin
      tick();
      for (int b = 0; b < ND; b++) full[b] = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 99) == 0) prio_mode = ~prio_mode;
      if ($urandom_range(0, 2) == 0) begin
        rdrv = $urandom_range(0, ND - 1);
        rsel = $urandom_range(0, 99);
        if (rsel < 70)      rdst = $urandom_range(0, ND - 1);
        else if (rsel < 85) rdst = 255;
        else                rdst = $urandom_range(ND, 254);
        rpkt = {8'(rdst), 8'($urandom)};
        if (tx_q[rdrv].size() < 4) send(rdrv, rpkt);
      end
    end
    full = '0;
    wait_drain(2000);
    check("final_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
